aes_encrypt_iter: RTL and testbench
===================================

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have no parameters; the block is fixed AES-128, 10 rounds.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  plaintext and key are offered.
REQ-005 in_ready  output  1  block can accept a new plaintext and key.
REQ-006 data_in  input  128  plaintext; byte 0 = bits [127:120]; state element s[r][c] = byte 4c+r.
REQ-007 key  input  128  cipher key; same byte order as data_in.
REQ-008 out_valid  output  1  data_out holds a finished ciphertext.
REQ-009 out_ready  input  1  consumer takes data_out.
REQ-010 data_out  output  128  ciphertext; same byte order as data_in.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 Accept: in IDLE with in_valid=1, the block SHALL do all of the following on the same edge:
- state <= data_in ^ key
- round key <= key
- round counter <= 1
- FSM goes to RUN
REQ-014 In RUN, each cycle SHALL compute one round, in this order: SubBytes (using the existing subbytes block), ShiftRows, MixColumns, AddRoundKey.
REQ-015 MixColumns SHALL be bypassed when the round counter = 10.
REQ-016 The next round key SHALL be derived combinationally from the current round key, using rcon[round]:
- rcon = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36
- rotate word 3, SubWord, XOR rcon into the top byte, then the XOR chain across words 0..3
- the derived key SHALL be registered together with the state.
REQ-017 Round counter behaviour:
- increments 1..10 in RUN
- at round 10, FSM goes to DONE
- the counter SHALL never wrap or exceed 10.
REQ-018 Latency: accept at edge N; out_valid = 1 after edge N+10; data_out = final state register.
REQ-019 In DONE, data_out SHALL hold stable while out_ready = 0, for any number of cycles.
REQ-020 In DONE with out_ready = 1, the FSM SHALL go to IDLE on that edge.
- in_ready rises in the following cycle.
- Accept-to-accept throughput is therefore 12 cycles minimum.
REQ-021 Input handling outside IDLE:
- in_valid in RUN or DONE SHALL be ignored.
- data_in and key SHALL be sampled only on the accept edge; changes at any other time SHALL not affect the result.
REQ-022 MixColumns arithmetic SHALL be in GF(2^8) modulo x^8+x^4+x^3+x+1 (xtime reduces with 1B), with byte results kept to 8 bits.
REQ-023 data_out outside DONE is don't-care to the consumer, but SHALL equal the state register.

Reset
REQ-024 rst = 1 SHALL, on the next edge and from any state including mid-RUN, force:
- FSM = IDLE, round counter = 0
- state and round-key registers = 0
REQ-025 During and after reset: out_valid = 0 and in_ready = 1 in the first cycle after reset.
REQ-026 rst SHALL take priority over accept and over the out_ready handshake on the same edge.

Structure
REQ-027 The shared package aes_pkg SHALL hold:
- the FSM state enum
- the rcon table
- the xtime and MixColumns-column functions
- the 128-bit block width constant
REQ-028 One sub-module, key_expand_step, SHALL implement the round-key step.
- Inputs: 128-bit key and 8-bit rcon; output: next 128-bit key.
- Built from four sbox instances.
REQ-029 The datapath SHALL instantiate the existing subbytes block once; ShiftRows and MixColumns SHALL be combinational logic inside aes_encrypt_iter.

Verification
REQ-030 FIPS-197 App. B vector:
- key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
- required: data_out 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
REQ-031 FIPS-197 App. C.1 vector:
- key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
- required: data_out 69c4e0d86a7b0430d8cdb78070b4c55a
REQ-032 Backpressure: hold out_ready = 0 for 5 cycles in DONE.
- required: out_valid stays 1, data_out stays unchanged, in_ready stays 0
- then assert out_ready: IDLE follows on the next edge.
REQ-033 Reset mid-operation: assert rst at round 5, then apply the App. B vector.
- required: after the reset edge, out_valid = 0, in_ready = 1, round counter = 0
- the App. B vector then yields the correct ciphertext.
REQ-034 Interference: during RUN, toggle in_valid and change data_in/key to all-FF.
- required: output still matches the original vector, and no second accept occurs.
REQ-035 Back-to-back: drive the App. B then App. C.1 vectors with out_ready = 1 and in_valid held high.
- required: both correct ciphertexts, accepts exactly 12 cycles apart.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, block width, rcon table, S-box
// table and the GF(2^8) helpers used by the round datapath.
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Round constants for rounds 1..10, round 1 in the top byte.
  localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

  localparam logic [7:0] SBOX_TABLE [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // rcon for a round number; zero outside 1..10 (idle/reset) so the key
  // step output is harmless when it is not being used.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (round == 4'(i + 1)) r = RCON_TABLE[79 - 8*i -: 8];
    end
    return r;
  endfunction

  // Multiply by x in GF(2^8), reducing with x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 is the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/key_expand_step.sv
// One AES-128 key-schedule step: next round key from the current one.
module key_expand_step (
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_sub, w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    sbox u_sbox (.i_byte(w_rot[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
  end

  assign w_temp = w_sub ^ {i_rcon, 24'h000000};
  assign w_n0   = w_w0 ^ w_temp;
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;
  assign o_key  = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/sbox.sv
// Single AES S-box lookup.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX_TABLE[i_byte];

endmodule

// File: rtl/subbytes.sv
// SubBytes over a full 128-bit state: sixteen parallel S-boxes.
module subbytes (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    sbox u_sbox (.i_byte(i_state[8*g +: 8]), .o_byte(o_state[8*g +: 8]));
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, 10 rounds per block.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; in_ready is high only in IDLE, out_valid only in DONE, and the
// ciphertext holds steady in DONE until out_ready takes it.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [1:0]   o_dbg_state,
  output logic [3:0]   o_dbg_round
);

  state_t             r_fsm, w_fsm_next;
  logic [BLOCK_W-1:0] r_state, r_key;
  logic [3:0]         r_round;
  logic [BLOCK_W-1:0] w_sb, w_sr, w_mc, w_key_next, w_round_out;
  logic               w_accept, w_last;

  assign w_accept = (r_fsm == ST_IDLE) && in_valid;
  assign w_last   = (r_round == 4'd10);

  subbytes u_subbytes (.i_state(r_state), .o_state(w_sb));

  key_expand_step u_key_step (
    .i_key  (r_key),
    .i_rcon (rcon(r_round)),
    .o_key  (w_key_next)
  );

  // ShiftRows: row r of the state rotates left by r columns.
  always_comb begin
    w_sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[127 - 8*(4*c + r) -: 8] = w_sb[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
  end

  // MixColumns on each column, skipped in the final round.
  always_comb begin
    w_mc = w_sr;
    if (!w_last) begin
      for (int c = 0; c < 4; c++) begin
        w_mc[127 - 32*c -: 32] = mix_column(w_sr[127 - 32*c -: 32]);
      end
    end
  end

  assign w_round_out = w_mc ^ w_key_next;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_fsm_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_next = ST_IDLE;
      end
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, one round per RUN cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_key   <= '0;
      r_round <= 4'd0;
    end else if (w_accept) begin
      r_state <= data_in ^ key;
      r_key   <= key;
      r_round <= 4'd1;
    end else if (r_fsm == ST_RUN) begin
      r_state <= w_round_out;
      r_key   <= w_key_next;
      if (!w_last) r_round <= r_round + 4'd1;
    end
  end

  assign data_out    = r_state;
  assign o_dbg_state = r_fsm;
  assign o_dbg_round = r_round;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: a FIPS-197 style reference model (S-box built
// from GF(2^8) inverses, byte-array state), a per-cycle compare process,
// directed vectors and randomized traffic.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid;
  logic [127:0] data_out;
  logic [1:0]   dbg_state;
  logic [3:0]   dbg_round;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_encrypt_iter dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .key         (key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .o_dbg_state (dbg_state),
    .o_dbg_round (dbg_round)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, v;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; v = inv;
      for (int k = 0; k < 4; k++) begin
        v = rotl1(v);
        s = s ^ v;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31 - 8*r -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // Transaction-level timing model: 0 idle, 1 busy, 2 result waiting.
  int           m_phase = 0;
  int           m_round = 0;
  logic         m_started = 1'b0;
  logic         m_after_rst = 1'b0;
  logic [127:0] exp_q [$];
  int           acc_q [$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_phase = 0; m_round = 0; m_started = 1'b1; m_after_rst = 1'b1;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          exp_q.push_back(model_enc(data_in, key));
          acc_q.push_back(cyc);
          m_phase = 1; m_round = 1; m_after_rst = 1'b0;
        end
        1: if (m_round == 10) m_phase = 2; else m_round++;
        default: if (out_ready) begin
          m_phase = 0;
          void'(exp_q.pop_front());
        end
      endcase
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase == 1) chk("round_ctr", dbg_round, m_round);
      if (m_after_rst) begin
        chk("reset_round", dbg_round, 0);
        chk("reset_state", data_out, 0);
      end
      if (m_phase == 2 && exp_q.size() > 0) chk("data_out", data_out, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input logic [127:0] pt, input logic [127:0] k, input bit keep_valid);
    int n0;
    bit ok;
    n0 = acc_q.size();
    ok = 1'b0;
    @(posedge clk); #1;
    data_in = pt; key = k; in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (acc_q.size() > n0) ok = 1'b1;
    end
    if (!keep_valid) in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_result(input string name, input logic [127:0] lit, input bit use_lit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk({name, "_timeout"}, 1'b0, 1'b1);
    else begin
      if (use_lit) chk(name, data_out, lit);
      chk({name, "_latency"}, cyc - acc_q[acc_q.size()-1], 10);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] rpt, rkey;
    build_sbox();
    chk("model_sbox_00", sb[8'h00], 8'h63);
    chk("model_sbox_53", sb[8'h53], 8'hed);
    chk("model_vec_b", model_enc(PT_B, KEY_B), CT_B);
    chk("model_vec_c", model_enc(PT_C, KEY_C), CT_C);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // App. B with backpressure
    out_ready = 1'b0;
    drive_vec(PT_B, KEY_B, 1'b0);
    wait_result("vec_b", CT_B, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_ready", in_ready, 1'b0);
      chk("bp_data", data_out, CT_B);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_take", in_ready, 1'b1);

    // App. C.1
    out_ready = 1'b1;
    drive_vec(PT_C, KEY_C, 1'b0);
    wait_result("vec_c", CT_C, 1'b1);

    // Reset at round 5, then App. B again
    drive_vec(PT_B, KEY_B, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_round", dbg_round, 4'd0);
    drive_vec(PT_B, KEY_B, 1'b0);
    wait_result("vec_b_after_rst", CT_B, 1'b1);

    // Interference while running
    drive_vec(PT_C, KEY_C, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      data_in = '1; key = '1;
    end
    in_valid = 1'b0;
    wait_result("vec_c_interfere", CT_C, 1'b1);
    chk("interfere_accepts", acc_q.size(), 5);

    // Back-to-back with in_valid held high
    drive_vec(PT_B, KEY_B, 1'b1);
    data_in = PT_C; key = KEY_C;
    drive_vec(PT_C, KEY_C, 1'b0);
    chk("b2b_gap", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], 12);
    wait_result("vec_c_b2b", CT_C, 1'b1);

    // Randomized traffic with random backpressure and input noise
    for (int n = 0; n < 20; n++) begin
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      rkey = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drive_vec(rpt, rkey, 1'b0);
      for (int i = 0; i < 80 && m_phase != 0; i++) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        if (m_phase == 1) begin
          in_valid = 1'($urandom_range(0, 1));
          data_in  = {$urandom, $urandom, $urandom, $urandom};
          key      = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          in_valid = 1'b0;
        end
      end
      in_valid = 1'b0;
      if (m_phase != 0) chk("random_drain_timeout", 1'b0, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
